// File: rtl/flp_norm_seq.sv
// Multi-cycle mantissa normalizer feeding the IEEE-754 single packing stage.
// Define FLP_NORM_ROUND_NEAREST_EN to add a ROUND state (round half to even on the carry path).
module flp_norm_seq #(
  parameter int SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [24:0] in_man,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sign,
  output logic [7:0]  out_exp,
  output logic [22:0] out_frac,
  output logic        out_zero,
  output logic        out_uf,
  output logic        out_of,
  output logic        busy
);

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DETECT = 3'd1,
    S_SHIFT  = 3'd2,
    S_DONE   = 3'd3
`ifdef FLP_NORM_ROUND_NEAREST_EN
    , S_ROUND = 3'd4
`endif
  } state_t;

`ifdef FLP_NORM_ROUND_NEAREST_EN
  localparam state_t S_POST = S_ROUND;
`else
  localparam state_t S_POST = S_DONE;
`endif

  state_t state_reg, state_next;

  logic               sign_reg;
  logic signed [9:0]  exp_reg, exp_step;
  logic [24:0]        man_reg, man_step;
  logic [4:0]         k_reg, k_step;
  logic               zero_reg, zero_step;
  logic               pass_reg, pass_step;
`ifdef FLP_NORM_ROUND_NEAREST_EN
  logic               guard_reg, guard_step;
`endif
  logic [4:0]         lzc;
  logic               lz_zero;
  logic [4:0]         shamt;
  logic [7:0]         fin_exp;
  logic [22:0]        fin_frac;
  logic               fin_zero, fin_uf, fin_of;
  logic               accept, enter_done, leave_done;

  // Leading-one finder: bit 24 is position 0, so the highest set bit wins.
  always_comb begin
    lzc = 5'd0;
    for (int i = 0; i < 25; i++) begin
      if (man_reg[i]) lzc = 5'(24 - i);
    end
  end
  assign lz_zero = (man_reg == 25'd0);

  always_comb begin
    exp_step  = exp_reg;
    man_step  = man_reg;
    k_step    = k_reg;
    zero_step = zero_reg;
    pass_step = pass_reg;
    shamt     = 5'd0;
`ifdef FLP_NORM_ROUND_NEAREST_EN
    guard_step = guard_reg;
`endif
    case (state_reg)
      S_DETECT: begin
        zero_step = lz_zero;
        pass_step = !lz_zero && (exp_reg == 10'sd255);
        if (!lz_zero && !pass_step) begin
          if (lzc == 5'd0) begin
            man_step = man_reg >> 1;
            exp_step = exp_reg + 10'sd1;
`ifdef FLP_NORM_ROUND_NEAREST_EN
            guard_step = man_reg[0];
`endif
          end else begin
            k_step = lzc - 5'd1;
          end
        end
      end
      S_SHIFT: begin
        shamt    = (k_reg < STEP) ? k_reg : STEP;
        man_step = man_reg << shamt;
        exp_step = exp_reg - $signed({5'd0, shamt});
        k_step   = k_reg - shamt;
      end
`ifdef FLP_NORM_ROUND_NEAREST_EN
      S_ROUND: begin
        // Guard is the only dropped bit, so guard=1 is always a tie: round to even.
        if (guard_reg && man_reg[0]) begin
          man_step = man_reg + 25'd1;
          if (man_step[24]) begin
            man_step = man_step >> 1;
            exp_step = exp_reg + 10'sd1;
          end
        end
      end
`endif
      default: ;
    endcase
  end

  // Final packing decision, evaluated on the cycle that enters DONE.
  always_comb begin
    fin_exp  = 8'd0;
    fin_frac = 23'd0;
    fin_zero = 1'b0;
    fin_uf   = 1'b0;
    fin_of   = 1'b0;
    if (zero_step) begin
      fin_zero = 1'b1;
    end else if (pass_step) begin
      fin_exp  = 8'hff;
      fin_frac = man_step[22:0];
    end else if (exp_step <= 10'sd0) begin
      fin_uf   = 1'b1;
      fin_zero = 1'b1;
    end else if (exp_step >= 10'sd255) begin
      fin_of  = 1'b1;
      fin_exp = 8'hff;
    end else begin
      fin_exp  = exp_step[7:0];
      fin_frac = man_step[22:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (in_valid) state_next = S_DETECT;
      S_DETECT: begin
        if (zero_step || pass_step || (lzc <= 5'd1)) state_next = S_POST;
        else                                         state_next = S_SHIFT;
      end
      S_SHIFT:  if (k_step == 5'd0) state_next = S_POST;
`ifdef FLP_NORM_ROUND_NEAREST_EN
      S_ROUND:  state_next = S_DONE;
`endif
      S_DONE:   if (out_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == S_IDLE);
    out_valid = (state_reg == S_DONE);
    busy      = (state_reg != S_IDLE);
  end

  assign accept     = in_valid && (state_reg == S_IDLE);
  assign enter_done = (state_next == S_DONE) && (state_reg != S_DONE);
  assign leave_done = (state_reg == S_DONE) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_reg  <= 1'b0;
      exp_reg   <= 10'sd0;
      man_reg   <= 25'd0;
      k_reg     <= 5'd0;
      zero_reg  <= 1'b0;
      pass_reg  <= 1'b0;
`ifdef FLP_NORM_ROUND_NEAREST_EN
      guard_reg <= 1'b0;
`endif
    end else if (accept) begin
      sign_reg  <= in_sign;
      exp_reg   <= $signed({2'b00, in_exp});
      man_reg   <= in_man;
      k_reg     <= 5'd0;
      zero_reg  <= 1'b0;
      pass_reg  <= 1'b0;
`ifdef FLP_NORM_ROUND_NEAREST_EN
      guard_reg <= 1'b0;
`endif
    end else begin
      exp_reg   <= exp_step;
      man_reg   <= man_step;
      k_reg     <= k_step;
      zero_reg  <= zero_step;
      pass_reg  <= pass_step;
`ifdef FLP_NORM_ROUND_NEAREST_EN
      guard_reg <= guard_step;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sign <= 1'b0;
      out_exp  <= 8'd0;
      out_frac <= 23'd0;
      out_zero <= 1'b0;
      out_uf   <= 1'b0;
      out_of   <= 1'b0;
    end else if (enter_done) begin
      out_sign <= sign_reg;
      out_exp  <= fin_exp;
      out_frac <= fin_frac;
      out_zero <= fin_zero;
      out_uf   <= fin_uf;
      out_of   <= fin_of;
    end else if (leave_done) begin
      out_sign <= 1'b0;
      out_exp  <= 8'd0;
      out_frac <= 23'd0;
      out_zero <= 1'b0;
      out_uf   <= 1'b0;
      out_of   <= 1'b0;
    end
  end

endmodule
